aurora_link_supervisor: RTL

// - Sequences Aurora bring-up on init_clk: drives gt_reset/tx_reset in a PMA-hold / gap / GT-pulse pattern.
// - Waits for lane_up then channel_up, qualifies channel stability, then asserts link_ready plus a 3-cycle start pulse.
// - Retries the full sequence on timeout, link drop or hard error; latches fail after MAX_RETRIES retries.
// - Sits between the board enable/reset logic and the Aurora core reset pins; replaces free-running power-up sequencing.

---
 rtl/aurora_sup_pkg.sv | 31 +++
 rtl/aurora_sync2.sv | 23 ++
 rtl/aurora_link_supervisor.sv | 121 ++++++++++++
 3 files changed

// File: rtl/aurora_sup_pkg.sv
// Shared types and constants for the Aurora link supervisor.
package aurora_sup_pkg;

  // Ten states do not fit in three bits. The debug code folds FAIL onto IDLE
  // and RETRY onto RESET_HOLD.
  typedef enum logic [3:0] {
    ST_IDLE       = 4'h0,
    ST_RESET_HOLD = 4'h1,
    ST_GT_GAP     = 4'h2,
    ST_GT_PULSE   = 4'h3,
    ST_WAIT_LANE  = 4'h4,
    ST_WAIT_CHAN  = 4'h5,
    ST_STABLE     = 4'h6,
    ST_READY      = 4'h7,
    ST_FAIL       = 4'h8,
    ST_RETRY      = 4'h9
  } sup_state_e;

  localparam int unsigned START_LEN = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [2:0] state_dbg_code(input sup_state_e s);
    logic [3:0] raw;
    raw = s;
    return raw[2:0];
  endfunction

endpackage

// File: rtl/aurora_sync2.sv
// Two-flop synchronizer for level signals crossing into init_clk.
module aurora_sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         init_clk,
  input  logic         RST,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge init_clk) begin
    if (RST) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aurora_link_supervisor.sv
// Aurora bring-up supervisor: reset sequencing, link qualification, retry and fail.
module aurora_link_supervisor
  import aurora_sup_pkg::*;
#(
  parameter int unsigned LANES         = 1,
  parameter int unsigned PMA_WAIT      = 490,
  parameter int unsigned TX_HOLD       = 100,
  parameter int unsigned GT_GAP        = 10,
  parameter int unsigned GT_PULSE      = 10,
  parameter int unsigned LINK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic             init_clk,
  input  logic             RST,
  input  logic             enable,
  input  logic [LANES-1:0] lane_up,
  input  logic             channel_up,
  input  logic             hard_err,
  output logic             gt_reset,
  output logic             tx_reset,
  output logic             link_ready,
  output logic             start,
  output logic [3:0]       retry_count,
  output logic             fail,
  output logic [2:0]       state_dbg
);

  localparam int unsigned T_MAX = max_u(max_u(max_u(PMA_WAIT, TX_HOLD), max_u(GT_GAP, GT_PULSE)),
                                        max_u(LINK_TIMEOUT, STABLE_CYCLES));
  localparam int unsigned CW = $clog2(T_MAX) + 1;

  logic [LANES-1:0] lane_s;
  logic             chan_s;
  logic             herr_s;

  aurora_sync2 #(.W(LANES)) u_sync_lane (.init_clk(init_clk), .RST(RST), .d(lane_up),    .q(lane_s));
  aurora_sync2 #(.W(1))     u_sync_chan (.init_clk(init_clk), .RST(RST), .d(channel_up), .q(chan_s));
  aurora_sync2 #(.W(1))     u_sync_herr (.init_clk(init_clk), .RST(RST), .d(hard_err),   .q(herr_s));

  sup_state_e    state;
  sup_state_e    nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  function automatic logic reached(input logic [CW-1:0] c, input int unsigned n);
    return (32'(c) + 32'd1) >= n;
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:       if (enable) nxt = ST_RESET_HOLD;
      ST_RESET_HOLD: if (reached(cnt, PMA_WAIT)) nxt = ST_GT_GAP;
      ST_GT_GAP:     if (reached(cnt, GT_GAP)) nxt = ST_GT_PULSE;
      ST_GT_PULSE:   if (reached(cnt, GT_PULSE)) nxt = ST_WAIT_LANE;
      ST_WAIT_LANE: begin
        if (&lane_s) nxt = ST_WAIT_CHAN;
        else if (reached(cnt, LINK_TIMEOUT)) nxt = ST_RETRY;
      end
      ST_WAIT_CHAN: begin
        if (chan_s) nxt = ST_STABLE;
        else if (reached(cnt, LINK_TIMEOUT)) nxt = ST_RETRY;
      end
      // The WAIT_CHAN cycle that saw channel_up counts as the first stable cycle.
      ST_STABLE: begin
        if (herr_s || !chan_s) nxt = ST_RETRY;
        else if (reached(cnt, STABLE_CYCLES - 1)) nxt = ST_READY;
      end
      ST_READY:      if (herr_s || !chan_s) nxt = ST_RETRY;
      ST_RETRY:      nxt = (retry_count >= 4'(MAX_RETRIES)) ? ST_FAIL : ST_RESET_HOLD;
      ST_FAIL:       nxt = ST_FAIL;
      default:       nxt = ST_IDLE;
    endcase
    if (!enable) nxt = ST_IDLE;
    cnt_nxt = (nxt != state) ? '0 : ((cnt == '1) ? cnt : cnt + 1'b1);
  end

  always_ff @(posedge init_clk) begin
    if (RST) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      gt_reset    <= 1'b1;
      tx_reset    <= 1'b1;
      link_ready  <= 1'b0;
      start       <= 1'b0;
      retry_count <= '0;
      fail        <= 1'b0;
      state_dbg   <= '0;
    end else begin
      state      <= nxt;
      cnt        <= cnt_nxt;
      state_dbg  <= state_dbg_code(nxt);
      gt_reset   <= 1'b1;
      tx_reset   <= 1'b0;
      link_ready <= 1'b0;
      start      <= 1'b0;
      fail       <= 1'b0;
      case (nxt)
        ST_IDLE, ST_RETRY: tx_reset <= 1'b1;
        ST_FAIL: begin
          tx_reset <= 1'b1;
          fail     <= 1'b1;
        end
        ST_RESET_HOLD: tx_reset <= (32'(cnt_nxt) < TX_HOLD);
        ST_GT_GAP, ST_WAIT_LANE, ST_WAIT_CHAN, ST_STABLE: gt_reset <= 1'b0;
        ST_READY: begin
          gt_reset   <= 1'b0;
          link_ready <= 1'b1;
          start      <= (32'(cnt_nxt) < START_LEN);
        end
        default: ;
      endcase
      if (nxt == ST_IDLE)
        retry_count <= '0;
      else if (state == ST_RETRY && nxt == ST_RESET_HOLD && retry_count < 4'(MAX_RETRIES))
        retry_count <= retry_count + 1'b1;
    end
  end

endmodule
